// File: rtl/game_pkg.sv
// Shared step codes, quadrant constants and target-selection helper for the
// quadrant-guess round sequencer and its downstream comparator.
package game_pkg;

  localparam int QUAD_W = 3;
  localparam int STEP_W = 4;

  localparam logic [QUAD_W-1:0] QUAD_NONE = 3'b111;

  typedef enum logic [STEP_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_SHOW    = 4'd1,
    ST_CD1     = 4'd2,
    ST_CD2     = 4'd3,
    ST_CD3     = 4'd4,
    ST_SELECT  = 4'd5,
    ST_SETTLE  = 4'd6,
    ST_COMPARE = 4'd7,
    ST_RESULT  = 4'd8
  } step_e;

  // Low LFSR bits masked to the quadrant range; top bit is always 0 so a
  // target can never equal QUAD_NONE.
  function automatic logic [QUAD_W-1:0] pick_target(input logic [1:0] lfsr_lo,
                                                    input int num_quad);
    logic [1:0] mask;
    mask = 2'(num_quad - 1);
    return {1'b0, lfsr_lo & mask};
  endfunction

endpackage

// File: rtl/game_round_sequencer_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 7,5,4,3); holds the seed while in reset.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [7:0] state_o
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) state_d = {state_q[6:0], state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3]};
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= SEED;
    else      state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/game_round_sequencer.sv
// One round of the quadrant-guess game: show target, count down, capture the
// player's pick, give the comparator time to settle, then score the result.
module game_round_sequencer
  import game_pkg::*;
#(
  parameter int         STEP_CYCLES  = 4,
  parameter int         SEL_TIMEOUT  = 10,
  parameter int         COMPARE_HOLD = 4,
  parameter int         NUM_QUAD     = 4,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel_valid,
  input  logic [2:0] sel_quad,
  input  logic       restart,
  input  logic       win_in,
  output logic [3:0] step,
  output logic [2:0] cuadranterandom,
  output logic [2:0] icuadrante,
  output logic [3:0] score,
  output logic       busy
);

  localparam int CNT_W = 8;

  step_e            step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       tgt_q, tgt_d;
  logic [2:0]       iq_q, iq_d;
  logic [3:0]       score_q, score_d;
  logic             busy_q, busy_d;
  logic [7:0]       lfsr_w;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (1'b1),
    .state_o (lfsr_w)
  );

  always_comb begin
    step_d  = step_q;
    cnt_d   = cnt_q + CNT_W'(1);
    tgt_d   = tgt_q;
    iq_d    = iq_q;
    score_d = score_q;

    // Counter is 0 only on the first cycle of RESULT, so win_in is sampled once.
    if (step_q == ST_RESULT && cnt_q == '0 && win_in && score_q != 4'hF)
      score_d = score_q + 4'd1;

    case (step_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          step_d = ST_SHOW;
          tgt_d  = pick_target(lfsr_w[1:0], NUM_QUAD);
        end
      end
      ST_SHOW, ST_CD1, ST_CD2, ST_CD3: begin
        if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
          cnt_d = '0;
          case (step_q)
            ST_SHOW: step_d = ST_CD1;
            ST_CD1:  step_d = ST_CD2;
            ST_CD2:  step_d = ST_CD3;
            default: step_d = ST_SELECT;
          endcase
        end
      end
      ST_SELECT: begin
        if (sel_valid) begin
          iq_d   = sel_quad;
          step_d = ST_SETTLE;
          cnt_d  = '0;
        end else if (cnt_q == CNT_W'(SEL_TIMEOUT - 1)) begin
          iq_d   = QUAD_NONE;
          step_d = ST_SETTLE;
          cnt_d  = '0;
        end
      end
      ST_SETTLE: begin
        step_d = ST_COMPARE;
        cnt_d  = '0;
      end
      ST_COMPARE: begin
        if (cnt_q == CNT_W'(COMPARE_HOLD - 1)) begin
          step_d = ST_RESULT;
          cnt_d  = '0;
        end
      end
      ST_RESULT: begin
        cnt_d = CNT_W'(1);
        if (start) begin
          step_d = ST_SHOW;
          tgt_d  = pick_target(lfsr_w[1:0], NUM_QUAD);
          cnt_d  = '0;
        end
      end
      default: begin
        step_d = ST_IDLE;
        cnt_d  = '0;
      end
    endcase

    // Abort from anywhere but IDLE; in IDLE a simultaneous start takes effect.
    if (restart && step_q != ST_IDLE) begin
      step_d = ST_IDLE;
      cnt_d  = '0;
    end

    busy_d = (step_d != ST_IDLE) && (step_d != ST_RESULT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      step_q  <= ST_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      iq_q    <= '0;
      score_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      iq_q    <= iq_d;
      score_q <= score_d;
      busy_q  <= busy_d;
    end
  end

  assign step            = step_q;
  assign cuadranterandom = tgt_q;
  assign icuadrante      = iq_q;
  assign score           = score_q;
  assign busy            = busy_q;

endmodule

// File: doc/game_round_sequencer.md
Name: game_round_sequencer

Overview:
- Drives one game round of the quadrant-guess game.
- Generates the 4-bit step code and the random target quadrant, and captures the player's quadrant selection.
- Feeds the downstream selection comparator on step / icuadrante / cuadranterandom.
- Consumes the comparator's win result to keep a saturating score for the VGA overlay.

Parameters:
- STEP_CYCLES, 4, clock cycles spent in each display step 1..4.
- SEL_TIMEOUT, 10, clock cycles allowed in step 5 before auto-miss.
- COMPARE_HOLD, 4, cycles step stays at 7; must be >= 3 to cover the comparator's 2-cycle registered output.
- NUM_QUAD, 4, number of quadrants; legal values 2 or 4; targets are 0..NUM_QUAD-1.
- LFSR_SEED, 8'hA5, nonzero LFSR reset value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start  in  1  begin round; honoured in step 0 and step 8 only
- sel_valid  in  1  player selection strobe; honoured in step 5 only
- sel_quad  in  3  player's quadrant, qualified by sel_valid
- restart  in  1  abort/return to step 0; any step
- win_in  in  1  comparator win output
- step  out  4  round phase code, 0..8
- cuadranterandom  out  3  target quadrant
- icuadrante  out  3  captured player quadrant
- score  out  4  rounds won, saturating
- busy  out  1  high when step is not 0 and not 8

Behaviour:
- Clock and reset: all state updates on posedge clk.
- While rst==0, registers hold their reset values:
  - step=0, cuadranterandom=0, icuadrante=0, score=0, busy=0.
  - lfsr=LFSR_SEED; phase counter=0.
- LFSR:
  - 8-bit, free-running every cycle when out of reset, never zero.
  - Update: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Steps:
  - 0 IDLE: wait for start. On start: step<=1, cuadranterandom<={1'b0, lfsr[1:0] masked to NUM_QUAD-1}, sampled from the current lfsr value. Counter cleared.
  - 1 SHOW: target displayed. Each of steps 1..4 lasts exactly STEP_CYCLES cycles, then advances by 1 with the counter reset.
  - 2..4 COUNTDOWN: same timing as step 1.
  - 5 SELECT:
    - sel_valid: icuadrante<=sel_quad, step<=6.
    - Counter reaching SEL_TIMEOUT-1 without sel_valid: icuadrante<=3'b111 (never matches a target), step<=6.
    - sel_valid in the same cycle as timeout: the selection wins.
  - 6 SETTLE: exactly 1 cycle, so icuadrante is stable before compare; step<=7.
  - 7 COMPARE: held exactly COMPARE_HOLD cycles, then step<=8.
  - 8 RESULT:
    - On the first cycle of step 8, score increments if win_in==1; saturates at 15.
    - Hold until start (-> step 1 with a new target, same sampling as step 0) or restart (-> step 0).
- restart:
  - Any step other than 0: step<=0, counter cleared on the next edge.
  - cuadranterandom, icuadrante and score are retained.
  - restart and start asserted together: restart wins, except in step 0 where start wins.
- Ignored inputs: start in steps 1..7; sel_valid outside step 5.
- Out-of-range selection: sel_quad >= NUM_QUAD is accepted as-is and yields a mismatch downstream.
- Only rst clears score.
- rst asserted mid-round: full reset on that edge, no partial state.
- Output timing: all outputs are registered; no combinational path from input to output.

Decomposition:
- Shared package game_pkg:
  - step code localparams: ST_IDLE=0, ST_SHOW=1, ST_CD1..3=2..4, ST_SELECT=5, ST_SETTLE=6, ST_COMPARE=7, ST_RESULT=8.
  - QUAD_NONE=3'b111.
  - Quadrant width constant 3 and step width constant 4.
  - The comparator imports the same step codes.
- Sub-module: lfsr8 (seed parameter, enable input, 8-bit state output).

Test Plan:
1. rst low 3 cycles, release; start in the first cycle after release -> step=1 next edge, cuadranterandom=1 (0xA5[1:0]=01); step goes 1,2,3,4 at 4-cycle intervals, reaching 5 after 16 cycles.
2. In step 5, sel_valid with sel_quad=1 on the 3rd cycle -> icuadrante=1, step 6 for 1 cycle, step 7 for 4 cycles, then 8; win_in=1 on entry to 8 -> score=1.
3. No sel_valid in step 5 -> after 10 cycles icuadrante=7, step=6; win_in=0 in step 8 -> score unchanged.
4. restart during step 3 -> step=0 next edge; cuadranterandom and score retained; later start and restart asserted together in step 0 -> step=1.
5. Win 16 consecutive rounds, each restarted with start from step 8 -> score stays 15 after the 15th win.
6. rst asserted during step 7 with score=5 -> step=0, score=0, lfsr=0xA5; sel_valid asserted in step 2 -> icuadrante unchanged.
